rename_ctrl: RTL

// Rename-stage controller: sequences the speculative map table and free-tag pool between decode and dispatch.
// Per decoded instr: reads src mappings, allocates dst phys tag, updates map; frees old tags at commit.

---
 rtl/rename_pkg.sv | 32 +++
 rtl/tag_free_list.sv | 86 ++++++++
 rtl/rename_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/rename_pkg.sv
// Shared sizing, FSM state and renamed-uop payload for the rename controller.
package rename_pkg;

    localparam int unsigned NUM_ARCH = 16;
    localparam int unsigned NUM_PHYS = 64;

    // Index width for a table of n entries
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned AREG_W = idx_width(NUM_ARCH);
    localparam int unsigned TAG_W  = idx_width(NUM_PHYS);
    localparam int unsigned CNT_W  = idx_width(NUM_PHYS + 1);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RECOVER = 2'd2
    } rename_state_t;

    typedef struct packed {
        logic [TAG_W-1:0] src1_tag;
        logic [TAG_W-1:0] src2_tag;
        logic             src1_rdy;
        logic             src2_rdy;
        logic [TAG_W-1:0] dst_tag;
        logic [TAG_W-1:0] old_tag;
        logic             dst_en;
    } ren_uop_t;

endpackage

// File: rtl/tag_free_list.sv
// Free physical-tag pool: bitmap, lowest-index allocator, free count, bulk restore.
module tag_free_list
    import rename_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_init,
    input  logic                i_alloc,
    input  logic                i_free,
    input  logic [TAG_W-1:0]    i_free_tag,
    input  logic                i_restore,
    input  logic [NUM_PHYS-1:0] i_restore_free,
    output logic [TAG_W-1:0]    o_alloc_tag_c,
    output logic [CNT_W-1:0]    o_free_cnt,
    output logic                o_empty
);

    localparam logic [NUM_PHYS-1:0] INIT_FREE = {{(NUM_PHYS-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};
    localparam logic [CNT_W-1:0]    INIT_CNT  = CNT_W'(NUM_PHYS - NUM_ARCH);

    logic [NUM_PHYS-1:0] r_free;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_empty;
    logic [NUM_PHYS-1:0] w_free_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_restore_cnt;
    logic [TAG_W-1:0]    w_alloc_tag;

    // Lowest-index free tag (scan downward so the lowest hit is written last)
    always_comb begin
        w_alloc_tag = '0;
        for (int i = int'(NUM_PHYS) - 1; i >= 0; i--) begin
            if (r_free[i]) w_alloc_tag = TAG_W'(i);
        end
    end

    // Population count of the restore bitmap
    always_comb begin
        w_restore_cnt = '0;
        for (int unsigned i = 0; i < NUM_PHYS; i++) begin
            w_restore_cnt = w_restore_cnt + CNT_W'(i_restore_free[i]);
        end
    end

    // Next pool state; a freed tag only becomes visible to the allocator next cycle
    always_comb begin
        w_free_nxt = r_free;
        w_cnt_nxt  = r_cnt;
        if (i_init) begin
            w_free_nxt = INIT_FREE;
            w_cnt_nxt  = INIT_CNT;
        end else if (i_restore) begin
            w_free_nxt = i_restore_free;
            w_cnt_nxt  = w_restore_cnt;
        end else begin
            if (i_free)  w_free_nxt[i_free_tag]  = 1'b1;
            if (i_alloc) w_free_nxt[w_alloc_tag] = 1'b0;
            w_cnt_nxt = r_cnt + CNT_W'(i_free) - CNT_W'(i_alloc);
        end
    end

    // Pool state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_free  <= INIT_FREE;
            r_cnt   <= INIT_CNT;
            r_empty <= 1'b0;
        end else begin
            r_free  <= w_free_nxt;
            r_cnt   <= w_cnt_nxt;
            r_empty <= (w_cnt_nxt == '0);
        end
    end

    assign o_alloc_tag_c = w_alloc_tag;
    assign o_free_cnt    = r_cnt;
    assign o_empty       = r_empty;

    a_no_double_free: assert property (@(posedge clk) disable iff (reset)
        i_free |-> !r_free[i_free_tag]);
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        i_alloc |-> (r_cnt != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        (i_free && !i_alloc && !i_restore && !i_init) |-> (r_cnt < CNT_W'(NUM_PHYS)));

endmodule

// File: rtl/rename_ctrl.sv
// Rename-stage controller: speculative/committed map tables, tag allocation, flush recovery.
module rename_ctrl
    import rename_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [AREG_W-1:0] dec_src1,
    input  logic [AREG_W-1:0] dec_src2,
    input  logic [AREG_W-1:0] dec_dst,
    input  logic              dec_dst_en,
    output logic              ren_valid,
    input  logic              ren_ready,
    output logic [TAG_W-1:0]  ren_src1_tag,
    output logic [TAG_W-1:0]  ren_src2_tag,
    output logic              ren_src1_rdy,
    output logic              ren_src2_rdy,
    output logic [TAG_W-1:0]  ren_dst_tag,
    output logic [TAG_W-1:0]  ren_old_tag,
    output logic              ren_dst_en,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic              cmt_valid,
    input  logic              cmt_dst_en,
    input  logic [AREG_W-1:0] cmt_dst,
    input  logic [TAG_W-1:0]  cmt_new_tag,
    input  logic [TAG_W-1:0]  cmt_old_tag,
    input  logic              flush,
    output logic              out_of_tags
);

    localparam logic [NUM_PHYS-1:0] INIT_READY = {{(NUM_PHYS-NUM_ARCH){1'b0}}, {NUM_ARCH{1'b1}}};

    rename_state_t       r_state, w_state_nxt;
    logic [TAG_W-1:0]    r_map      [NUM_ARCH];
    logic [TAG_W-1:0]    r_cmap     [NUM_ARCH];
    logic [TAG_W-1:0]    w_cmap_nxt [NUM_ARCH];
    logic [NUM_PHYS-1:0] r_ready, w_ready_nxt, w_cmt_alloc;
    ren_uop_t            r_uop, w_uop;
    logic                r_ren_valid;
    logic                w_dec_ready, w_accept, w_alloc, w_commit, w_flush;
    logic                w_init, w_recover, w_empty;
    logic [TAG_W-1:0]    w_alloc_tag;
    logic [CNT_W-1:0]    w_free_cnt;

    assign w_init    = (r_state == ST_INIT);
    assign w_recover = (r_state == ST_RECOVER);
    assign w_flush   = flush && !w_init;
    assign w_commit  = cmt_valid && cmt_dst_en && !w_init;
    assign w_accept  = dec_valid && w_dec_ready;
    assign w_alloc   = w_accept && dec_dst_en;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_INIT;
        else       r_state <= w_state_nxt;
    end

    // Next state and decode handshake
    always_comb begin
        w_state_nxt = r_state;
        w_dec_ready = 1'b0;
        case (r_state)
            ST_INIT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                w_dec_ready = !flush && (!r_ren_valid || ren_ready) && (w_free_cnt != '0);
                if (flush) w_state_nxt = ST_RECOVER;
            end
            ST_RECOVER: if (!flush) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Committed map including this cycle's commit, and the set of tags it holds
    always_comb begin
        w_cmap_nxt  = r_cmap;
        w_cmt_alloc = '0;
        if (w_commit) w_cmap_nxt[cmt_dst] = cmt_new_tag;
        for (int unsigned a = 0; a < NUM_ARCH; a++) w_cmt_alloc[w_cmap_nxt[a]] = 1'b1;
    end

    // Speculative and committed map tables
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned a = 0; a < NUM_ARCH; a++) begin
                r_map[a]  <= TAG_W'(a);
                r_cmap[a] <= TAG_W'(a);
            end
        end else if (w_init) begin
            for (int unsigned a = 0; a < NUM_ARCH; a++) begin
                r_map[a]  <= TAG_W'(a);
                r_cmap[a] <= TAG_W'(a);
            end
        end else begin
            if (w_recover)    r_map <= w_cmap_nxt;
            else if (w_alloc) r_map[dec_dst] <= w_alloc_tag;
            r_cmap <= w_cmap_nxt;
        end
    end

    // Ready bits: set by writeback and recovery, cleared on allocation
    always_comb begin
        w_ready_nxt = r_ready;
        if (wb_valid)  w_ready_nxt[wb_tag] = 1'b1;
        if (w_recover) w_ready_nxt = w_ready_nxt | w_cmt_alloc;
        if (w_alloc)   w_ready_nxt[w_alloc_tag] = 1'b0;
    end

    // Ready bit register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       r_ready <= INIT_READY;
        else if (w_init) r_ready <= INIT_READY;
        else             r_ready <= w_ready_nxt;
    end

    // Rename lookup against the pre-update map, with writeback bypass on source readiness
    always_comb begin
        w_uop          = '0;
        w_uop.src1_tag = r_map[dec_src1];
        w_uop.src2_tag = r_map[dec_src2];
        w_uop.src1_rdy = r_ready[w_uop.src1_tag] || (wb_valid && (wb_tag == w_uop.src1_tag));
        w_uop.src2_rdy = r_ready[w_uop.src2_tag] || (wb_valid && (wb_tag == w_uop.src2_tag));
        w_uop.dst_en   = dec_dst_en;
        if (dec_dst_en) begin
            w_uop.dst_tag = w_alloc_tag;
            w_uop.old_tag = r_map[dec_dst];
        end
    end

    // Output stage: load on accept, hold while stalled, squash on flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ren_valid <= 1'b0;
            r_uop       <= '0;
        end else if (w_flush) begin
            r_ren_valid <= 1'b0;
        end else if (w_accept) begin
            r_ren_valid <= 1'b1;
            r_uop       <= w_uop;
        end else if (ren_ready) begin
            r_ren_valid <= 1'b0;
        end
    end

    tag_free_list u_free_list (
        .clk            (clk),
        .reset          (reset),
        .i_init         (w_init),
        .i_alloc        (w_alloc),
        .i_free         (w_commit),
        .i_free_tag     (cmt_old_tag),
        .i_restore      (w_recover),
        .i_restore_free (~w_cmt_alloc),
        .o_alloc_tag_c  (w_alloc_tag),
        .o_free_cnt     (w_free_cnt),
        .o_empty        (w_empty)
    );

    assign dec_ready    = w_dec_ready;
    assign ren_valid    = r_ren_valid;
    assign ren_src1_tag = r_uop.src1_tag;
    assign ren_src2_tag = r_uop.src2_tag;
    assign ren_src1_rdy = r_uop.src1_rdy;
    assign ren_src2_rdy = r_uop.src2_rdy;
    assign ren_dst_tag  = r_uop.dst_tag;
    assign ren_old_tag  = r_uop.old_tag;
    assign ren_dst_en   = r_uop.dst_en;
    assign out_of_tags  = w_empty;

endmodule
